adc_init_seq: RTL and testbench
===============================

// Module: adc_init_seq
// PURPOSE
//   Downstream consumer of the power-on-reset FSM's ADC_INIT_RST. While ADC_INIT_RST is high it holds the ADC
//   serial interface idle. On release it waits a power-up delay, then writes NREG 16-bit configuration words
//   from an external table over a write-only SPI bus. It then raises ADC_RDY, which closes the POR FSM's ADC_INIT state.
// PARAMETERS
//   NREG     8        number of table words written per sequence (1..16)
//   SCLK_DIV 4        CLK cycles per SCLK half-period (>=1); SCLK = CLK/(2*SCLK_DIV)
//   PWR_DLY  16'd1000 CLK cycles waited after ADC_INIT_RST falls before first word (>=1)
//   GAP_CYC  8        CLK cycles ADC_CS_B held high between words (>=1)
// PORTS
//   CLK          in  1  system clock
//   EOS          in  1  asynchronous active-low reset
//   ADC_INIT_RST in  1  sync, active-high sequence restart/hold (from POR FSM)
//   ROM_DATA     in  16 table word at ROM_ADDR, combinational, valid same cycle
//   ROM_ADDR     out 4  table index of word being loaded
//   ADC_CS_B     out 1  SPI chip select, active low, shared by all ADCs
//   ADC_SCLK     out 1  SPI clock, idles low
//   ADC_SDATA    out 1  SPI data, MSB first
//   ADC_RDY      out 1  configuration complete, level
//   SEQ_STATE    out 3  current state encoding, for debug/readback
// BEHAVIOUR
//   Registered outputs only.
//   Reset (EOS=0) and ADC_INIT_RST=1 both force the following:
//     - state Idle
//     - ADC_CS_B=1, ADC_SCLK=0, ADC_SDATA=0, ADC_RDY=0, ROM_ADDR=0
//     - all counters 0
//   ADC_INIT_RST is synchronous and overrides every state, including mid-word. There is no partial word
//   completion; the next cycle shows idle bus values.
//   States (SEQ_STATE): Idle=0, Pwr_Wait=1, Load=2, Shift=3, Gap=4, Ready=5.
//   Idle: if ADC_INIT_RST=0, go to Pwr_Wait (1 cycle); else stay.
//   Pwr_Wait: dly_cnt counts 0..PWR_DLY-1; at PWR_DLY-1 go to Load.
//   Load (1 cycle): sreg<=ROM_DATA, ADC_CS_B<=0, ADC_SDATA<=ROM_DATA[15], ADC_SCLK stays 0; go to Shift.
//   Shift: div_cnt counts 0..SCLK_DIV-1; at each terminal count ADC_SCLK toggles.
//     - On a 1->0 toggle, sreg shifts left and ADC_SDATA<=next bit. Data is stable for the whole high phase;
//       the ADC samples on the rising edge.
//     - After the 16th high phase ends (SCLK returns 0), ADC_CS_B<=1 and go to Gap.
//     - ADC_CS_B is low for exactly 1+32*SCLK_DIV CLK cycles per word.
//   Gap: GAP_CYC cycles with ADC_CS_B=1, then one of:
//     - if ROM_ADDR==NREG-1: go to Ready
//     - else: ROM_ADDR<=ROM_ADDR+1 and go to Load.
//   Ready: ADC_RDY=1, bus idle; hold until ADC_INIT_RST=1.
//     ADC_RDY rises on the first cycle in Ready. It falls the cycle after ADC_INIT_RST is sampled high.
//   ROM_ADDR: 4-bit, never wraps (stops at NREG-1).
//   Out-of-range SEQ_STATE values (6,7): recover to Idle next cycle with idle outputs.
// TESTING (SCLK_DIV=2, NREG=3, PWR_DLY=10, GAP_CYC=4, table 16'hA5C3,16'h0001,16'h8000)
//   1. Hold EOS=0 for 5 cycles, then release with ADC_INIT_RST=1 -> ADC_CS_B=1, ADC_SCLK=0, ADC_RDY=0,
//      SEQ_STATE=0 throughout.
//   2. Drop ADC_INIT_RST:
//      - first ADC_CS_B falling edge occurs 12 cycles later
//      - SPI monitor captures A5C3, 0001, 8000 in order, each with ADC_CS_B low 65 cycles and >=4-cycle gaps
//      - ADC_RDY=1 one cycle after the last gap.
//   3. Check SDATA stable across every SCLK high phase -> exactly 16 rising edges per ADC_CS_B low window, 48 total.
//   4. Assert ADC_INIT_RST mid-word 2 (bit 7) -> next cycle ADC_CS_B=1, SCLK=0, ROM_ADDR=0.
//      After release, full 3-word sequence restarts from word 0.
//   5. In Ready, pulse ADC_INIT_RST for 1 cycle -> ADC_RDY drops the next cycle; sequence reruns; ADC_RDY returns.
//   6. Assert EOS=0 asynchronously during Shift -> outputs idle immediately without a CLK edge; SEQ_STATE=0.

Source files
------------

// File: rtl/adc_init_seq.sv
// adc_init_seq: after the power-on-reset FSM releases ADC_INIT_RST, waits a
// power-up delay, then streams NREG 16-bit configuration words from an
// external table to the ADCs over a write-only SPI bus (MSB first, SCLK idle
// low, data stable across each SCLK high phase), and finally raises ADC_RDY.
// Every output is a flop. SEQ_STATE exposes the state register for readback.
module adc_init_seq #(
  parameter int          NREG     = 8,
  parameter int          SCLK_DIV = 4,
  parameter logic [15:0] PWR_DLY  = 16'd1000,
  parameter int          GAP_CYC  = 8
) (
  input  logic        CLK,
  input  logic        EOS,
  input  logic        ADC_INIT_RST,
  input  logic [15:0] ROM_DATA,
  output logic [3:0]  ROM_ADDR,
  output logic        ADC_CS_B,
  output logic        ADC_SCLK,
  output logic        ADC_SDATA,
  output logic        ADC_RDY,
  output logic [2:0]  SEQ_STATE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_LOAD     = 3'd2,
    S_SHIFT    = 3'd3,
    S_GAP      = 3'd4,
    S_READY    = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [15:0] DLY_LAST  = PWR_DLY - 16'd1;
  localparam logic [3:0]  ADDR_LAST = 4'(NREG - 1);
  // 16 bits -> 32 SCLK edges per word
  localparam logic [5:0]  TOG_LAST  = 6'd32;

  state_t      state;
  logic [15:0] dly_cnt;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [5:0]  tog_cnt;
  logic [15:0] sreg;

  assign SEQ_STATE = state;

  // Sequencer: reset, the sync restart and illegal state codes all drop the
  // bus to idle at once; there is no attempt to finish a word in flight.
  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state     <= S_IDLE;
      ADC_CS_B  <= 1'b1;
      ADC_SCLK  <= 1'b0;
      ADC_SDATA <= 1'b0;
      ADC_RDY   <= 1'b0;
      ROM_ADDR  <= 4'd0;
      dly_cnt   <= 16'd0;
      div_cnt   <= 16'd0;
      gap_cnt   <= 16'd0;
      tog_cnt   <= 6'd0;
      sreg      <= 16'd0;
    end else if (ADC_INIT_RST) begin
      state     <= S_IDLE;
      ADC_CS_B  <= 1'b1;
      ADC_SCLK  <= 1'b0;
      ADC_SDATA <= 1'b0;
      ADC_RDY   <= 1'b0;
      ROM_ADDR  <= 4'd0;
      dly_cnt   <= 16'd0;
      div_cnt   <= 16'd0;
      gap_cnt   <= 16'd0;
      tog_cnt   <= 6'd0;
      sreg      <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          dly_cnt <= 16'd0;
          state   <= S_PWR_WAIT;
        end

        S_PWR_WAIT: begin
          if (dly_cnt == DLY_LAST) begin
            dly_cnt <= 16'd0;
            state   <= S_LOAD;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end

        // Chip select drops here; the MSB is presented before the first rise.
        S_LOAD: begin
          sreg      <= ROM_DATA;
          ADC_CS_B  <= 1'b0;
          ADC_SDATA <= ROM_DATA[15];
          ADC_SCLK  <= 1'b0;
          div_cnt   <= 16'd0;
          tog_cnt   <= 6'd0;
          state     <= S_SHIFT;
        end

        // After the 32nd SCLK edge (SCLK back low) the select is held one
        // more cycle, giving a low window of 1 + 32*SCLK_DIV cycles.
        S_SHIFT: begin
          if (tog_cnt == TOG_LAST) begin
            ADC_CS_B  <= 1'b1;
            ADC_SDATA <= 1'b0;
            tog_cnt   <= 6'd0;
            div_cnt   <= 16'd0;
            gap_cnt   <= 16'd0;
            state     <= S_GAP;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= 16'd0;
            ADC_SCLK <= ~ADC_SCLK;
            tog_cnt  <= tog_cnt + 6'd1;
            // Data only moves on the falling edge so it is stable while high.
            if (ADC_SCLK) begin
              sreg      <= {sreg[14:0], 1'b0};
              ADC_SDATA <= sreg[14];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 16'd0;
            if (ROM_ADDR == ADDR_LAST) begin
              ADC_RDY <= 1'b1;
              state   <= S_READY;
            end else begin
              ROM_ADDR <= ROM_ADDR + 4'd1;
              state    <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        S_READY: begin
          ADC_RDY   <= 1'b1;
          ADC_CS_B  <= 1'b1;
          ADC_SCLK  <= 1'b0;
          ADC_SDATA <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          ADC_CS_B  <= 1'b1;
          ADC_SCLK  <= 1'b0;
          ADC_SDATA <= 1'b0;
          ADC_RDY   <= 1'b0;
          ROM_ADDR  <= 4'd0;
          dly_cnt   <= 16'd0;
          div_cnt   <= 16'd0;
          gap_cnt   <= 16'd0;
          tog_cnt   <= 6'd0;
          sreg      <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_init_seq.sv
// Bench for adc_init_seq: an SPI monitor captures words, window lengths,
// rise counts, gaps and ADC_RDY latency; directed steps compare them with
// values worked out from the table contents and the timing parameters.
module tb_adc_init_seq;

  localparam int          NREG      = 3;
  localparam int          SCLK_DIV  = 2;
  localparam logic [15:0] PWR_DLY   = 16'd10;
  localparam int          GAP_CYC   = 4;
  localparam int          WIN_LEN   = 1 + 32 * SCLK_DIV;
  localparam int          FIRST_LAT = 2 + int'(PWR_DLY);
  localparam logic [31:0] IDLE_VEC  = 32'h400;

  logic        CLK = 1'b0;
  logic        EOS;
  logic        ADC_INIT_RST;
  logic [15:0] ROM_DATA;
  logic [3:0]  ROM_ADDR;
  logic        ADC_CS_B;
  logic        ADC_SCLK;
  logic        ADC_SDATA;
  logic        ADC_RDY;
  logic [2:0]  SEQ_STATE;

  logic [15:0] rom_tbl [16];
  logic [15:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  adc_init_seq #(
    .NREG(NREG), .SCLK_DIV(SCLK_DIV), .PWR_DLY(PWR_DLY), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLK(CLK), .EOS(EOS), .ADC_INIT_RST(ADC_INIT_RST), .ROM_DATA(ROM_DATA),
    .ROM_ADDR(ROM_ADDR), .ADC_CS_B(ADC_CS_B), .ADC_SCLK(ADC_SCLK),
    .ADC_SDATA(ADC_SDATA), .ADC_RDY(ADC_RDY), .SEQ_STATE(SEQ_STATE)
  );

  // clock / table
  always #5 CLK = ~CLK;
  assign ROM_DATA = rom_tbl[ROM_ADDR];

  // SPI monitor (samples on the falling CLK edge)
  logic [15:0] got_q[$];
  int          len_q[$];
  int          rise_q[$];
  int          gap_q[$];
  int          rdy_q[$];
  int          stab_err = 0;
  int          idle_err = 0;
  int          max_addr = 0;
  int          cur_len = 0;
  int          cur_rise = 0;
  int          hi_cnt = 0;
  logic [15:0] cur_word = 16'd0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        held_sd = 1'b0;
  logic        have_win = 1'b0;
  logic        mon_clr = 1'b0;

  always @(negedge CLK) begin
    if (mon_clr) begin
      got_q.delete(); len_q.delete(); rise_q.delete(); gap_q.delete(); rdy_q.delete();
      stab_err = 0; idle_err = 0; max_addr = 0;
      cur_len = 0; cur_rise = 0; hi_cnt = 0; cur_word = 16'd0; have_win = 1'b0;
    end else begin
      if (ADC_RDY === 1'b1 && prev_rdy !== 1'b1) rdy_q.push_back(hi_cnt);
      if (ADC_CS_B === 1'b0) begin
        if (prev_cs === 1'b1) begin
          if (have_win) gap_q.push_back(hi_cnt);
          cur_len = 0; cur_rise = 0; cur_word = 16'd0;
        end
        cur_len++;
        if (ADC_SCLK === 1'b1 && prev_sclk !== 1'b1) begin
          cur_rise++;
          cur_word = {cur_word[14:0], ADC_SDATA};
          held_sd  = ADC_SDATA;
        end else if (ADC_SCLK === 1'b1 && ADC_SDATA !== held_sd) begin
          stab_err++;
        end
      end else begin
        if (prev_cs === 1'b0) begin
          got_q.push_back(cur_word);
          len_q.push_back(cur_len);
          rise_q.push_back(cur_rise);
          have_win = 1'b1;
          hi_cnt   = 0;
        end
        hi_cnt++;
        if (ADC_SCLK !== 1'b0) idle_err++;
      end
      if (int'(ROM_ADDR) > max_addr) max_addr = int'(ROM_ADDR);
    end
    prev_cs   = ADC_CS_B;
    prev_sclk = ADC_SCLK;
    prev_rdy  = ADC_RDY;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({ADC_CS_B, ADC_SCLK, ADC_SDATA, ADC_RDY, ROM_ADDR, SEQ_STATE}), IDLE_VEC);
  endtask

  // Reference: the words expected on the bus are simply the first NREG table entries.
  task automatic load_table(input bit rand_tbl);
    for (int i = 0; i < 16; i++)
      rom_tbl[i] = rand_tbl ? 16'($urandom_range(0, 65535)) : 16'd0;
    if (!rand_tbl) begin
      rom_tbl[0] = 16'hA5C3;
      rom_tbl[1] = 16'h0001;
      rom_tbl[2] = 16'h8000;
    end
    exp_q.delete();
    for (int i = 0; i < NREG; i++) exp_q.push_back(rom_tbl[i]);
  endtask

  // Called just after a rising edge: drops ADC_INIT_RST and checks a full run.
  task automatic run_sequence(input string tag);
    int n;
    int total;
    bit seen;
    mon_clr      = 1'b1;
    ADC_INIT_RST = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < FIRST_LAT + 20; i++) begin
      @(posedge CLK); #1;
      mon_clr = 1'b0;
      n++;
      if (ADC_CS_B === 1'b0) begin seen = 1'b1; break; end
    end
    check({tag, " first_cs_lat"}, seen ? n : -1, FIRST_LAT);
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #1;
      if (ADC_RDY === 1'b1) begin seen = 1'b1; break; end
    end
    check({tag, " rdy_timeout"}, 32'(seen), 32'd1);
    @(negedge CLK); #1;
    check({tag, " word_count"}, got_q.size(), exp_q.size());
    total = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s cs_low%0d", tag, i), len_q[i], WIN_LEN);
        check($sformatf("%s rises%0d", tag, i), rise_q[i], 16);
        total += rise_q[i];
      end
    end
    check({tag, " total_rises"}, total, 16 * NREG);
    check({tag, " gap_count"}, gap_q.size(), NREG - 1);
    for (int i = 0; i < gap_q.size(); i++)
      check($sformatf("%s gap%0d", tag, i), gap_q[i], GAP_CYC + 1);
    check({tag, " rdy_rises"}, rdy_q.size(), 1);
    if (rdy_q.size() > 0) check({tag, " rdy_lat"}, rdy_q[0], GAP_CYC);
    check({tag, " sdata_stable"}, stab_err, 0);
    check({tag, " sclk_idle"}, idle_err, 0);
    check({tag, " max_addr"}, max_addr, NREG - 1);
    check({tag, " ready_state"}, 32'(SEQ_STATE), 32'd5);
  endtask

  initial begin
    int hold;
    bit seen;

    // step 1: power-on reset, then held by ADC_INIT_RST
    EOS = 1'b0;
    ADC_INIT_RST = 1'b1;
    load_table(1'b0);
    repeat (5) begin @(posedge CLK); #1; check_idle("por_hold"); end
    EOS = 1'b1;
    hold = $urandom_range(3, 8);
    repeat (hold) begin @(posedge CLK); #1; check_idle("init_rst_hold"); end

    // steps 2/3: specification table
    run_sequence("spec_tbl");

    // step 5: single-cycle restart pulse from Ready, random table
    load_table(1'b1);
    ADC_INIT_RST = 1'b1;
    @(posedge CLK); #1;
    check("rdy_fall", 32'(ADC_RDY), 32'd0);
    check_idle("pulse_idle");
    run_sequence("rerun");

    // step 4: abort during word 2, bit 7
    ADC_INIT_RST = 1'b1;
    @(posedge CLK); #1;
    mon_clr = 1'b1;
    ADC_INIT_RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      mon_clr = 1'b0;
      if (got_q.size() == 1 && ADC_CS_B === 1'b0 && cur_rise == 9) begin seen = 1'b1; break; end
    end
    check("abort_reach", 32'(seen), 32'd1);
    if (got_q.size() > 0) check("abort_word0", 32'(got_q[0]), 32'(exp_q[0]));
    ADC_INIT_RST = 1'b1;
    @(posedge CLK); #1;
    check_idle("abort_idle");
    run_sequence("restart");

    // step 6: asynchronous EOS during Shift
    load_table(1'b1);
    ADC_INIT_RST = 1'b1;
    @(posedge CLK); #1;
    mon_clr = 1'b1;
    ADC_INIT_RST = 1'b0;
    seen = 1'b0;
    hold = $urandom_range(2, 14);
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      mon_clr = 1'b0;
      if (ADC_CS_B === 1'b0 && cur_rise >= hold) begin seen = 1'b1; break; end
    end
    check("eos_reach", 32'(seen), 32'd1);
    check("eos_pre_state", 32'(SEQ_STATE), 32'd3);
    #2;
    EOS = 1'b0;
    #1;
    check_idle("eos_async");
    ADC_INIT_RST = 1'b1;
    @(posedge CLK); #1;
    check_idle("eos_hold");
    EOS = 1'b1;
    @(posedge CLK); #1;
    check_idle("eos_release");
    run_sequence("post_eos");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
